// File: rtl/dectape_fe_server.sv
// Tape front-end server: round-robin service of tu56 line requests onto one tape-image memory port.
// Optional per-unit overrun detection is built when DECTAPE_FE_OVERRUN_EN is defined.
module dectape_fe_server #(
   parameter int NUNITS   = 8,
   parameter int UW       = 3,
   parameter int POSW     = 20,
   parameter int TAPE_LEN = 922512
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4*NUNITS-1:0]  fe_rq,
   input  logic [5*NUNITS-1:0]  fe_readdata,
   output logic [NUNITS-1:0]    fe_read,
   output logic [NUNITS-1:0]    fe_write,
   output logic [7:0]           fe_writedata,
   output logic [UW+POSW-1:0]   mem_addr,
   output logic                 mem_rd,
   output logic                 mem_wr,
   output logic [3:0]           mem_wdata,
   input  logic [3:0]           mem_rdata,
   input  logic                 mem_ack,
   input  logic                 pos_we,
   input  logic [UW-1:0]        pos_unit,
   input  logic [POSW-1:0]      pos_data,
   output logic [POSW-1:0]      pos_out,
   output logic                 busy,
   output logic [NUNITS-1:0]    overrun
);

   localparam logic [POSW-1:0] POS_MAX = POSW'(TAPE_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_MRD, S_GIVE, S_TAKE, S_SAMP, S_MRD2, S_MWR, S_UPD
   } state_t;

   state_t            state_q, state_d;
   logic [NUNITS-1:0] wr_q, rd_q, wr_now, rd_now, wr_rise, rd_rise;
   logic [NUNITS-1:0] pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d, clr_wr, clr_rd;
   logic [POSW-1:0]   pos_q [NUNITS];
   logic [UW-1:0]     unit_q, unit_d, last_q, last_d, win;
   logic              found, is_take_q, is_take_d;
   logic [1:0]        dir_q, dir_d;
   logic [POSW-1:0]   apos_q, apos_d;
   logic [3:0]        rdata_q, rdata_d, wdata_q, wdata_d, line_q, line_d;

   function automatic logic [POSW-1:0] step_pos(input logic [POSW-1:0] p, input logic [1:0] d);
      logic [POSW-1:0] r;
      r = p;
      case (d)
         2'b10:   if (p < POS_MAX) r = p + POSW'(1); else r = p;
         2'b11:   if (p != '0) r = p - POSW'(1); else r = p;
         default: r = p;
      endcase
      return r;
   endfunction

   function automatic logic [POSW-1:0] clamp_pos(input logic [POSW-1:0] p);
      return (p > POS_MAX) ? POS_MAX : p;
   endfunction

   always_comb begin
      wr_now  = '0;
      rd_now  = '0;
      for (int u = 0; u < NUNITS; u++) begin
         wr_now[u] = fe_rq[4*u];
         rd_now[u] = fe_rq[4*u+1];
      end
      wr_rise   = wr_now & ~wr_q;
      rd_rise   = rd_now & ~rd_q;
      pend_wr_d = (pend_wr_q & ~clr_wr) | wr_rise;
      pend_rd_d = (pend_rd_q & ~clr_rd) | rd_rise;
   end

   // Round-robin scan starting just after the last granted unit.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = 1; i <= NUNITS; i++) begin
         if (!found && (pend_wr_q[(int'(last_q) + i) % NUNITS] || pend_rd_q[(int'(last_q) + i) % NUNITS])) begin
            found = 1'b1;
            win   = UW'((int'(last_q) + i) % NUNITS);
         end else begin
            found = found;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      unit_d    = unit_q;
      last_d    = last_q;
      is_take_d = is_take_q;
      dir_d     = dir_q;
      apos_d    = apos_q;
      rdata_d   = rdata_q;
      wdata_d   = wdata_q;
      line_d    = line_q;
      clr_wr    = '0;
      clr_rd    = '0;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               unit_d    = win;
               is_take_d = pend_rd_q[win];
               dir_d     = fe_rq[4*int'(win)+2 +: 2];
               apos_d    = pos_q[win];
               state_d   = pend_rd_q[win] ? S_TAKE : S_MRD;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_MRD: begin
            if (mem_ack) begin
               rdata_d = mem_rdata;
               state_d = S_GIVE;
            end else begin
               state_d = S_MRD;
            end
         end
         S_GIVE: state_d = S_UPD;
         S_TAKE: state_d = S_SAMP;
         S_SAMP: begin
            line_d = fe_readdata[5*int'(unit_q) +: 4];
            if (fe_readdata[5*int'(unit_q)+4]) begin
               wdata_d = fe_readdata[5*int'(unit_q) +: 4];
               state_d = S_MWR;
            end else begin
               state_d = S_MRD2;
            end
         end
         // Unmarked line: keep the stored mark bit, replace the data bits.
         S_MRD2: begin
            if (mem_ack) begin
               wdata_d = {mem_rdata[3], line_q[2:0]};
               state_d = S_MWR;
            end else begin
               state_d = S_MRD2;
            end
         end
         S_MWR: begin
            if (mem_ack) state_d = S_UPD; else state_d = S_MWR;
         end
         S_UPD: begin
            if (is_take_q) clr_rd[unit_q] = 1'b1; else clr_wr[unit_q] = 1'b1;
            last_d  = unit_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         wr_q      <= '0;
         rd_q      <= '0;
         pend_wr_q <= '0;
         pend_rd_q <= '0;
         unit_q    <= '0;
         last_q    <= '0;
         is_take_q <= 1'b0;
         dir_q     <= 2'b00;
         apos_q    <= '0;
         rdata_q   <= 4'h0;
         wdata_q   <= 4'h0;
         line_q    <= 4'h0;
      end else begin
         state_q   <= state_d;
         wr_q      <= wr_now;
         rd_q      <= rd_now;
         pend_wr_q <= pend_wr_d;
         pend_rd_q <= pend_rd_d;
         unit_q    <= unit_d;
         last_q    <= last_d;
         is_take_q <= is_take_d;
         dir_q     <= dir_d;
         apos_q    <= apos_d;
         rdata_q   <= rdata_d;
         wdata_q   <= wdata_d;
         line_q    <= line_d;
      end
   end

   // A host load beats the service update on the same unit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int u = 0; u < NUNITS; u++) pos_q[u] <= '0;
      end else begin
         for (int u = 0; u < NUNITS; u++) begin
            if (pos_we && (pos_unit == UW'(u))) pos_q[u] <= clamp_pos(pos_data);
            else if ((state_q == S_UPD) && (unit_q == UW'(u))) pos_q[u] <= step_pos(pos_q[u], dir_q);
            else pos_q[u] <= pos_q[u];
         end
      end
   end

   assign fe_write     = (state_q == S_GIVE) ? (NUNITS'(1) << unit_q) : '0;
   assign fe_read      = (state_q == S_TAKE) ? (NUNITS'(1) << unit_q) : '0;
   assign fe_writedata = (state_q == S_GIVE) ? {4'h0, rdata_q} : 8'h00;
   assign mem_rd       = (state_q == S_MRD) || (state_q == S_MRD2);
   assign mem_wr       = (state_q == S_MWR);
   assign mem_addr     = {unit_q, apos_q};
   assign mem_wdata    = wdata_q;
   assign pos_out      = pos_q[pos_unit];
   assign busy         = (state_q != S_IDLE);

`ifdef DECTAPE_FE_OVERRUN_EN
   logic [NUNITS-1:0] ovr_q, ovr_set, ovr_clr;

   always_comb begin
      ovr_set = (wr_rise & pend_wr_q & ~clr_wr) | (rd_rise & pend_rd_q & ~clr_rd);
      ovr_clr = pos_we ? (NUNITS'(1) << pos_unit) : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ovr_q <= '0;
      else       ovr_q <= (ovr_q & ~ovr_clr) | ovr_set;
   end

   assign overrun = ovr_q;
`else
   assign overrun = '0;
`endif

endmodule

// File: tb/tb_dectape_fe_server.sv
// Self-checking bench for dectape_fe_server: randomized and directed line services
// checked against a tape model (positions + memory image) kept in the bench.
module tb_dectape_fe_server;

   localparam int TAPE = 922512;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] fe_rq;
   logic [39:0] fe_readdata;
   logic [7:0]  fe_read, fe_write, fe_writedata, overrun;
   logic [22:0] mem_addr;
   logic        mem_rd, mem_wr, busy;
   logic [3:0]  mem_wdata;
   logic [3:0]  mem_rdata = 4'h0;
   logic        mem_ack = 1'b0;
   logic        pos_we;
   logic [2:0]  pos_unit;
   logic [19:0] pos_data, pos_out;

   int checks = 0;
   int failures = 0;

   // storage image (written only by tasks), model image and model positions
   logic [3:0]  stor [logic [22:0]];
   logic [3:0]  model_mem [logic [22:0]];
   int          model_pos [8];

   int ack_delay = 1;
   bit ack_hold  = 1'b0;

   // monitor logs (append-only)
   int          give_u [$];
   logic [7:0]  give_d [$];
   int          take_u [$];
   logic [26:0] wr_log [$];
   int          rd_cnt = 0;
   int          proto_err = 0;
   int          overlap_err = 0;

   dectape_fe_server dut (
      .clk(clk), .reset(reset), .fe_rq(fe_rq), .fe_readdata(fe_readdata),
      .fe_read(fe_read), .fe_write(fe_write), .fe_writedata(fe_writedata),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pos_we(pos_we), .pos_unit(pos_unit),
      .pos_data(pos_data), .pos_out(pos_out), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Memory responder: acks after ack_delay cycles, checks request stability.
   int          r_cnt = 0;
   bit          r_active = 1'b0;
   logic [22:0] r_addr;
   logic [3:0]  r_wd;
   logic        r_wr;
   always @(negedge clk) begin
      if (reset) begin
         mem_ack = 1'b0; r_cnt = 0; r_active = 1'b0;
      end else if (mem_ack) begin
         mem_ack = 1'b0; r_cnt = 0; r_active = 1'b0;
      end else if (mem_rd || mem_wr) begin
         if (mem_rd && mem_wr) proto_err++;
         if (!r_active) begin
            r_active = 1'b1; r_addr = mem_addr; r_wd = mem_wdata; r_wr = mem_wr;
         end else if (mem_addr !== r_addr || mem_wr !== r_wr || (mem_wr && mem_wdata !== r_wd)) begin
            proto_err++;
         end
         r_cnt++;
         if (!ack_hold && r_cnt >= ack_delay) begin
            mem_ack = 1'b1;
            if (mem_wr) begin
               wr_log.push_back({mem_addr, mem_wdata});
            end else begin
               mem_rdata = stor.exists(mem_addr) ? stor[mem_addr] : 4'h0;
               rd_cnt++;
            end
         end
      end
   end

   // Strobe monitor.
   always @(negedge clk) begin
      if (!reset) begin
         for (int u = 0; u < 8; u++) begin
            if (fe_write[u]) begin give_u.push_back(u); give_d.push_back(fe_writedata); end
            if (fe_read[u]) take_u.push_back(u);
         end
         if ($countones({fe_read, fe_write}) > 1) overlap_err++;
      end
   end

   function automatic logic [22:0] addr_of(input int u, input int p);
      return (23'(u) << 20) | 23'(p);
   endfunction

   function automatic int step_model(input int p, input logic [1:0] d);
      if (d == 2'b10) return (p >= TAPE - 1) ? TAPE - 1 : p + 1;
      else if (d == 2'b11) return (p == 0) ? 0 : p - 1;
      else return p;
   endfunction

   task automatic set_rq(input int u, input logic [3:0] v);
      @(negedge clk);
      fe_rq[4*u +: 4] = v;
   endtask

   task automatic set_pos(input int u, input int p);
      @(negedge clk);
      pos_we = 1'b1; pos_unit = 3'(u); pos_data = 20'(p);
      @(negedge clk);
      pos_we = 1'b0;
      model_pos[u] = (p >= TAPE) ? TAPE - 1 : p;
   endtask

   task automatic wait_quiet(input int budget);
      int idle, n;
      idle = 0; n = 0;
      while (idle < 3 && n < budget) begin
         @(negedge clk); n++;
         if (busy === 1'b0) idle++; else idle = 0;
      end
      checks++;
      if (idle < 3) begin
         failures++;
         $display("FAIL quiet_timeout busy=%0b required 0 within %0d cycles", busy, budget);
      end
   endtask

   task automatic give_once(input int u, input int p, input logic [1:0] d, input logic [3:0] w, input int dly);
      logic [22:0] a;
      int gb, rb, wb;
      a = addr_of(u, p);
      set_pos(u, p);
      stor[a] = w; model_mem[a] = w;
      ack_delay = dly;
      gb = give_u.size(); rb = rd_cnt; wb = wr_log.size();
      set_rq(u, {d, 2'b01});
      wait_quiet(200);
      set_rq(u, 4'b0000);
      model_pos[u] = step_model(model_pos[u], d);
      pos_unit = 3'(u); #1;
      checks++;
      if (give_u.size() - gb !== 1) begin
         failures++; $display("FAIL give_count unit=%0d got=%0d required=1", u, give_u.size() - gb);
      end else if (give_u[gb] !== u || give_d[gb] !== {4'h0, model_mem[a]}) begin
         failures++; $display("FAIL give_data unit=%0d got_unit=%0d got=%h required=%h", u, give_u[gb], give_d[gb], {4'h0, model_mem[a]});
      end
      checks++;
      if (rd_cnt - rb !== 1 || wr_log.size() !== wb) begin
         failures++; $display("FAIL give_mem reads=%0d writes=%0d required 1/0", rd_cnt - rb, wr_log.size() - wb);
      end
      checks++;
      if (pos_out !== 20'(model_pos[u])) begin
         failures++; $display("FAIL give_pos unit=%0d got=%0d required=%0d", u, pos_out, model_pos[u]);
      end
   endtask

   task automatic take_once(input int u, input int p, input logic [1:0] d, input logic [3:0] old,
                            input logic wrtm, input logic [3:0] line, input int dly);
      logic [22:0] a;
      logic [3:0]  nw, cur;
      int tb, rb, wb, gb;
      a = addr_of(u, p);
      set_pos(u, p);
      stor[a] = old; model_mem[a] = old;
      fe_readdata[5*u +: 5] = {wrtm, line};
      ack_delay = dly;
      tb = take_u.size(); rb = rd_cnt; wb = wr_log.size(); gb = give_u.size();
      set_rq(u, {d, 2'b10});
      wait_quiet(200);
      set_rq(u, 4'b0000);
      cur = model_mem[a];
      nw  = wrtm ? line : {cur[3], line[2:0]};
      model_mem[a] = nw; stor[a] = nw;
      model_pos[u] = step_model(model_pos[u], d);
      pos_unit = 3'(u); #1;
      checks++;
      if (take_u.size() - tb !== 1 || give_u.size() !== gb) begin
         failures++; $display("FAIL take_strobe unit=%0d takes=%0d gives=%0d required 1/0", u, take_u.size() - tb, give_u.size() - gb);
      end else if (take_u[tb] !== u) begin
         failures++; $display("FAIL take_unit got=%0d required=%0d", take_u[tb], u);
      end
      checks++;
      if (wr_log.size() - wb !== 1) begin
         failures++; $display("FAIL take_write_count got=%0d required=1", wr_log.size() - wb);
      end else if (wr_log[wb] !== {a, nw}) begin
         failures++; $display("FAIL take_write got=%h required=%h", wr_log[wb], {a, nw});
      end
      checks++;
      if (rd_cnt - rb !== (wrtm ? 0 : 1)) begin
         failures++; $display("FAIL take_reads got=%0d required=%0d", rd_cnt - rb, wrtm ? 0 : 1);
      end
      checks++;
      if (pos_out !== 20'(model_pos[u])) begin
         failures++; $display("FAIL take_pos unit=%0d got=%0d required=%0d", u, pos_out, model_pos[u]);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; fe_rq = '0; fe_readdata = '0; pos_we = 1'b0; pos_unit = '0; pos_data = '0;
      ack_hold = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int u = 0; u < 8; u++) model_pos[u] = 0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      int n;
      do_reset();
      checks++;
      if ({fe_read, fe_write, fe_writedata, mem_addr, mem_rd, mem_wr, mem_wdata, busy, overrun} !== '0) begin
         failures++; $display("FAIL reset_outputs got rd=%h wr=%h wd=%h addr=%h mrd=%b mwr=%b busy=%b ovr=%h required all 0",
                              fe_read, fe_write, fe_writedata, mem_addr, mem_rd, mem_wr, busy, overrun);
      end
      for (int u = 0; u < 8; u++) begin
         pos_unit = 3'(u); #1;
         checks++;
         if (pos_out !== 20'd0) begin failures++; $display("FAIL reset_pos unit=%0d got=%0d required=0", u, pos_out); end
      end
      // abort mid-read with an asynchronous reset
      set_pos(2, 33);
      ack_hold = 1'b1;
      set_rq(2, 4'b1001);
      n = 0;
      while (mem_rd !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (mem_rd !== 1'b1) begin failures++; $display("FAIL reset_stall mem_rd=%b required 1", mem_rd); end
      @(posedge clk); #2;
      reset = 1'b1; #1;
      checks++;
      if ({mem_rd, mem_wr, busy, fe_write, fe_read} !== '0) begin
         failures++; $display("FAIL reset_async mem_rd=%b mem_wr=%b busy=%b required 0", mem_rd, mem_wr, busy);
      end
      fe_rq = '0;
      do_reset();
      pos_unit = 3'd2; #1;
      checks++;
      if (pos_out !== 20'd0) begin failures++; $display("FAIL reset_pos_cleared got=%0d required=0", pos_out); end
   endtask

   task automatic test_give();
      give_once(0, 100, 2'b10, 4'hA, 2);
      give_once(7, 12345, 2'b11, 4'h5, 1);
      give_once(3, 777, 2'b00, 4'hC, 3);
   endtask

   task automatic test_take();
      take_once(2, 50, 2'b11, 4'hF, 1'b0, 4'h2, 1);
      take_once(2, 50, 2'b11, 4'hF, 1'b1, 4'h3, 2);
      take_once(6, 9, 2'b10, 4'h0, 1'b0, 4'hF, 3);
   endtask

   task automatic test_saturation();
      give_once(1, 0, 2'b11, 4'h7, 1);
      take_once(4, 0, 2'b11, 4'h8, 1'b0, 4'h1, 1);
      set_pos(6, 999999);
      pos_unit = 3'd6; #1;
      checks++;
      if (pos_out !== 20'd922511) begin failures++; $display("FAIL sat_load got=%0d required=922511", pos_out); end
      give_once(6, TAPE - 1, 2'b10, 4'h9, 2);
   endtask

   task automatic test_round_robin();
      int tb, wb;
      int exp_u [3];
      take_once(3, 10, 2'b00, 4'h0, 1'b1, 4'h5, 1);
      set_pos(1, 20); set_pos(3, 30); set_pos(5, 40);
      fe_readdata[5 +: 5] = {1'b1, 4'h1};
      fe_readdata[15 +: 5] = {1'b1, 4'h3};
      fe_readdata[25 +: 5] = {1'b1, 4'h5};
      ack_delay = 1;
      tb = take_u.size(); wb = wr_log.size();
      @(negedge clk);
      fe_rq[4 +: 4] = 4'b1010; fe_rq[12 +: 4] = 4'b1010; fe_rq[20 +: 4] = 4'b1010;
      wait_quiet(300);
      fe_rq = '0;
      exp_u[0] = 5; exp_u[1] = 1; exp_u[2] = 3;
      checks++;
      if (take_u.size() - tb !== 3) begin
         failures++; $display("FAIL rr_count got=%0d required=3", take_u.size() - tb);
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (take_u[tb+k] !== exp_u[k]) begin failures++; $display("FAIL rr_order slot=%0d got=%0d required=%0d", k, take_u[tb+k], exp_u[k]); end
         end
      end
      checks++;
      if (wr_log.size() - wb !== 3 || wr_log[wb] !== {addr_of(5, 40), 4'h5}) begin
         failures++; $display("FAIL rr_first_write n=%0d got=%h required=%h", wr_log.size() - wb, wr_log[wb], {addr_of(5, 40), 4'h5});
      end
      for (int k = 0; k < 3; k++) begin
         model_pos[exp_u[k]] = step_model(model_pos[exp_u[k]], 2'b10);
         pos_unit = 3'(exp_u[k]); #1;
         checks++;
         if (pos_out !== 20'(model_pos[exp_u[k]])) begin
            failures++; $display("FAIL rr_pos unit=%0d got=%0d required=%0d", exp_u[k], pos_out, model_pos[exp_u[k]]);
         end
      end
   endtask

   task automatic test_overrun();
      int gb, n, c0, c4;
      logic [7:0] exp_ovr;
      set_pos(0, 5); set_pos(4, 7);
      stor[addr_of(0, 5)] = 4'h6; stor[addr_of(4, 7)] = 4'hB;
      gb = give_u.size();
      ack_hold = 1'b1;
      set_rq(0, 4'b1001);
      n = 0;
      while (mem_rd !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      set_rq(4, 4'b0001); repeat (2) @(negedge clk);
      set_rq(4, 4'b0000); repeat (2) @(negedge clk);
      set_rq(4, 4'b0001); repeat (2) @(negedge clk);
`ifdef DECTAPE_FE_OVERRUN_EN
      exp_ovr = 8'h10;
`else
      exp_ovr = 8'h00;
`endif
      checks++;
      if (overrun !== exp_ovr) begin failures++; $display("FAIL overrun_set got=%h required=%h", overrun, exp_ovr); end
      ack_hold = 1'b0;
      wait_quiet(300);
      fe_rq = '0;
      c0 = 0; c4 = 0;
      for (int k = gb; k < give_u.size(); k++) begin
         if (give_u[k] == 0) c0++;
         if (give_u[k] == 4) c4++;
      end
      checks++;
      if (c0 !== 1 || c4 !== 1 || give_u.size() - gb !== 2) begin
         failures++; $display("FAIL overrun_gives unit0=%0d unit4=%0d total=%0d required 1/1/2", c0, c4, give_u.size() - gb);
      end
      set_pos(4, 7);
      #1;
      checks++;
      if (overrun !== 8'h00) begin failures++; $display("FAIL overrun_clear got=%h required=00", overrun); end
   endtask

   task automatic test_random();
      int u, p, r;
      for (int it = 0; it < 24; it++) begin
         u = $urandom_range(0, 7);
         r = $urandom_range(0, 3);
         p = (r == 0) ? 0 : (r == 1) ? TAPE - 1 : $urandom_range(0, TAPE - 1);
         if ($urandom_range(0, 1) == 0)
            give_once(u, p, 2'($urandom_range(0, 3)), 4'($urandom), $urandom_range(1, 4));
         else
            take_once(u, p, 2'($urandom_range(0, 3)), 4'($urandom), 1'($urandom), 4'($urandom), $urandom_range(1, 4));
      end
   endtask

   task automatic test_protocol();
      checks++;
      if (proto_err !== 0) begin failures++; $display("FAIL mem_protocol violations=%0d required=0", proto_err); end
      checks++;
      if (overlap_err !== 0) begin failures++; $display("FAIL strobe_overlap count=%0d required=0", overlap_err); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_give();
      test_take();
      test_saturation();
      test_round_robin();
      test_overrun();
      test_random();
      test_protocol();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
